// File: rtl/ram_init_loader.sv
// RAM front-end that either passes CPU accesses through, clears the whole RAM,
// or streams a block of downloaded words into it starting at a given base address.
module ram_init_loader #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8,
  parameter logic [data_width_g-1:0] clear_value_g = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear_req,
  input  logic                    load_req,
  input  logic [addr_width_g-1:0] load_base,
  input  logic [addr_width_g:0]   load_len,
  input  logic                    dl_valid,
  input  logic [data_width_g-1:0] dl_data,
  output logic                    dl_ready,
  input  logic [addr_width_g-1:0] cpu_address,
  input  logic [data_width_g-1:0] cpu_data,
  input  logic                    cpu_wren,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              load_sum,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [addr_width_g-1:0] last_addr = '1;
  localparam logic [addr_width_g:0]   one_left  = (addr_width_g+1)'(1);

  state_t                  state;
  logic [addr_width_g-1:0] addr_cnt;
  logic [addr_width_g:0]   remaining;
  logic [7:0]              dl_low;

  assign dl_low    = 8'(dl_data);
  assign fsm_state = state;

  // Download handshake: a word moves on a rising edge where dl_valid and
  // dl_ready are both high; dl_valid may drop at any time, dl_ready is only
  // high in LOAD and falls together with the final write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      remaining   <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      dl_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_sum    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          ram_address <= cpu_address;
          ram_data    <= cpu_data;
          ram_wren    <= cpu_wren;
          if (clear_req) begin
            // The entry edge already presents the write to address 0.
            state       <= CLEAR;
            busy        <= 1'b1;
            addr_cnt    <= '0;
            ram_address <= '0;
            ram_data    <= clear_value_g;
            ram_wren    <= 1'b1;
          end else if (load_req) begin
            if (load_len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= LOAD;
              busy      <= 1'b1;
              dl_ready  <= 1'b1;
              ram_wren  <= 1'b0;
              addr_cnt  <= load_base;
              remaining <= load_len;
              load_sum  <= '0;
            end
          end
        end

        CLEAR: begin
          if (addr_cnt == last_addr) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ram_wren <= 1'b0;
            done     <= 1'b1;
          end else begin
            addr_cnt    <= addr_cnt + 1'b1;
            ram_address <= addr_cnt + 1'b1;
          end
        end

        LOAD: begin
          ram_wren <= 1'b0;
          if (dl_valid && dl_ready) begin
            ram_address <= addr_cnt;
            ram_data    <= dl_data;
            ram_wren    <= 1'b1;
            addr_cnt    <= addr_cnt + 1'b1;
            load_sum    <= load_sum + dl_low;
            remaining   <= remaining - 1'b1;
            if (remaining == one_left) begin
              state    <= IDLE;
              busy     <= 1'b0;
              dl_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          dl_ready <= 1'b0;
          ram_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_init_loader.sv
// Bench for ram_init_loader: IDLE pass-through vectors, full clear, stalled and
// wrapping loads, CPU arbitration, mid-load reset and randomized loads.
module tb_ram_init_loader;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LOGSZ = 8192;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_len = '0;
  logic          dl_valid = 1'b0;
  logic [DW-1:0] dl_data = '0;
  logic          dl_ready;
  logic [AW-1:0] cpu_address = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_wren = 1'b0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          busy;
  logic          done;
  logic [7:0]    load_sum;
  logic [1:0]    fsm_state;

  ram_init_loader #(
    .addr_width_g (AW),
    .data_width_g (DW),
    .clear_value_g('0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .load_req   (load_req),
    .load_base  (load_base),
    .load_len   (load_len),
    .dl_valid   (dl_valid),
    .dl_data    (dl_data),
    .dl_ready   (dl_ready),
    .cpu_address(cpu_address),
    .cpu_data   (cpu_data),
    .cpu_wren   (cpu_wren),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .done       (done),
    .load_sum   (load_sum),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM-side observers ----------------
  // The RAM commits on the edge that ends the cycle the write is presented in.
  logic [AW+DW-1:0] wr_log [0:LOGSZ-1];
  int wr_n   = 0;
  int done_n = 0;

  always @(posedge clock) begin
    if (ram_wren) begin
      wr_log[wr_n % LOGSZ] <= {ram_address, ram_data};
      wr_n <= wr_n + 1;
    end
    if (done) done_n <= done_n + 1;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q [$];
  logic [DW-1:0]    words [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_writes(input string name, input int start);
    int n;
    int bad;
    n   = wr_n - start;
    bad = 0;
    check({name, "_write_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (wr_log[(start + i) % LOGSZ] !== exp_q[i]) bad++;
    check({name, "_bad_writes"}, bad, 0);
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Caller is at a falling edge; the request is seen on the next rising edge.
  task automatic run_load(input logic [AW-1:0] base, input int len, input int stop_after,
                          input bit cpu_poke);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    load_req  = 1'b1;
    load_base = base;
    load_len  = (AW+1)'(len);
    @(negedge clock);
    load_req = 1'b0;
    if (cpu_poke) begin
      cpu_address = 11'h123;
      cpu_data    = 8'h5A;
      cpu_wren    = 1'b1;
    end
    while (idx < stop_after && cyc < 500) begin
      rdy      = dl_ready;
      dl_valid = (cyc % 3 != 1) && ($urandom_range(0, 3) != 0);
      dl_data  = words[idx];
      @(negedge clock);
      if (dl_valid && rdy) idx++;
      cyc++;
    end
    dl_valid = 1'b0;
    cpu_wren = 1'b0;
    check("load_progress", idx, stop_after);
  endtask

  // Reference: word i lands at (base+i) mod depth, sum is the plain mod-256 total.
  task automatic do_check_load(input string name, input logic [AW-1:0] base, input bit poke);
    int start;
    int d0;
    int n;
    logic [7:0] sum;
    logic [AW-1:0] a;
    n   = words.size();
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      a = AW'((int'(base) + i) % DEPTH);
      exp_q.push_back({a, words[i]});
      sum = sum + 8'(words[i]);
    end
    start = wr_n;
    d0    = done_n;
    run_load(base, n, n, poke);
    check({name, "_done"}, done, 1);
    check({name, "_ready_drop"}, dl_ready, 0);
    check({name, "_busy_drop"}, busy, 0);
    check({name, "_sum"}, load_sum, sum);
    @(negedge clock);
    check({name, "_done_pulse_len"}, done, 0);
    idle(2);
    check_writes(name, start);
    check({name, "_done_count"}, done_n - d0, 1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wren;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_wren;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int start;
    int d0;
    int cnt;
    logic [AW-1:0] rb;

    // IDLE pass-through: RAM port shows the CPU access one cycle later.
    vecs[0] = '{11'h123, 8'h5A, 1'b1, 11'h123, 8'h5A, 1'b1};
    vecs[1] = '{11'h7FF, 8'hFF, 1'b0, 11'h7FF, 8'hFF, 1'b0};
    vecs[2] = '{11'h000, 8'h00, 1'b1, 11'h000, 8'h00, 1'b1};
    vecs[3] = '{11'h555, 8'hA5, 1'b1, 11'h555, 8'hA5, 1'b1};
    for (int i = 4; i < 8; i++) begin
      vecs[i].addr = AW'($urandom_range(0, DEPTH - 1));
      vecs[i].data = DW'($urandom_range(0, 255));
      vecs[i].wren = 1'($urandom_range(0, 1));
      vecs[i].exp_addr = vecs[i].addr;
      vecs[i].exp_data = vecs[i].data;
      vecs[i].exp_wren = vecs[i].wren;
    end

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_dl_ready", dl_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_sum", load_sum, 0);
    check("rst_state", fsm_state, 0);
    reset_n = 1'b1;

    // IDLE table
    for (int i = 0; i < 8; i++) begin
      cpu_address = vecs[i].addr;
      cpu_data    = vecs[i].data;
      cpu_wren    = vecs[i].wren;
      @(negedge clock);
      check("idle_addr", ram_address, vecs[i].exp_addr);
      check("idle_data", ram_data, vecs[i].exp_data);
      check("idle_wren", ram_wren, vecs[i].exp_wren);
      check("idle_busy", busy, 0);
      check("idle_ready", dl_ready, 0);
    end
    cpu_wren = 1'b0;
    idle(2);

    // Full clear, with a simultaneous load_req that must be dropped and
    // further requests during the clear that must be ignored.
    start     = wr_n;
    d0        = done_n;
    clear_req = 1'b1;
    load_req  = 1'b1;
    load_base = 11'h005;
    load_len  = 12'd4;
    @(negedge clock);
    clear_req = 1'b0;
    load_req  = 1'b0;
    cnt = 0;
    while (busy && cnt < 3000) begin
      load_req  = (cnt == 100);
      clear_req = (cnt == 200);
      cnt++;
      @(negedge clock);
    end
    load_req  = 1'b0;
    clear_req = 1'b0;
    check("clear_busy_cycles", cnt, DEPTH);
    check("clear_done", done, 1);
    @(negedge clock);
    check("clear_done_pulse_len", done, 0);
    idle(3);
    check("clear_busy_after", busy, 0);
    check("clear_state_after", fsm_state, 0);
    check("clear_done_count", done_n - d0, 1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), DW'(0)});
    check_writes("clear", start);

    // Load with stalls
    words = {8'h11, 8'h22, 8'h33, 8'h44};
    do_check_load("load_stall", 11'h010, 1'b0);
    check("load_stall_sum_const", load_sum, 8'hAA);

    // Address wrap
    words = {8'h01, 8'h02, 8'h03};
    do_check_load("load_wrap", 11'h7FE, 1'b0);

    // Zero-length load
    start     = wr_n;
    d0        = done_n;
    load_req  = 1'b1;
    load_base = 11'h050;
    load_len  = '0;
    @(negedge clock);
    load_req = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_ready", dl_ready, 0);
    @(negedge clock);
    check("len0_done_pulse_len", done, 0);
    idle(2);
    check("len0_writes", wr_n - start, 0);
    check("len0_done_count", done_n - d0, 1);

    // CPU write during LOAD is dropped; same access in IDLE goes through
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(DW'($urandom_range(0, 255)));
    do_check_load("arb_load", 11'h200, 1'b1);
    cpu_address = 11'h123;
    cpu_data    = 8'h5A;
    cpu_wren    = 1'b1;
    @(negedge clock);
    cpu_wren = 1'b0;
    check("arb_idle_wren", ram_wren, 1);
    check("arb_idle_addr", ram_address, 11'h123);
    check("arb_idle_data", ram_data, 8'h5A);
    idle(2);

    // Reset after 2 of 4 words
    words = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    exp_q.push_back({11'h300, 8'hC1});
    exp_q.push_back({11'h301, 8'hC2});
    start = wr_n;
    d0    = done_n;
    run_load(11'h300, 4, 2, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ram_wren", ram_wren, 0);
    check("mid_rst_ram_address", ram_address, 0);
    check("mid_rst_ram_data", ram_data, 0);
    check("mid_rst_dl_ready", dl_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_load_sum", load_sum, 0);
    check("mid_rst_state", fsm_state, 0);
    @(negedge clock);
    check("mid_rst_done_count", done_n - d0, 0);
    check_writes("mid_rst", start);
    reset_n = 1'b1;
    words = {8'h0F, 8'hF0, 8'h3C};
    do_check_load("post_rst_load", 11'h400, 1'b0);

    // Randomized loads against the reference
    for (int k = 0; k < 6; k++) begin
      rb = AW'($urandom_range(0, DEPTH - 1));
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++)
        words.push_back(DW'($urandom_range(0, 255)));
      do_check_load("rand_load", rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
